ps2_keypad_rx: RTL
==================

# ps2_keypad_rx

Parametrised PS/2 keyboard front end, the next generation of the `PS2Receiver` game-input block. It synchronises the keyboard clock and data lines and deframes 11-bit PS/2 frames, with optional parity checking and an inactivity timeout. It tracks E0 (extended) and F0 (break) prefixes and keeps a held/released bitmap of game keys for 1 or 2 players. It also emits a scancode event stream and a debug byte for the board LEDs.

## Interface
- `NUM_PLAYERS`, 2 — players mapped, 1 or 2.
- `SYNC_STAGES`, 2 — synchroniser flops on `keyb_clk`/`kdata`, minimum 2.
- `TIMEOUT_CYCLES`, 20000 — `clk` cycles without a keyboard falling edge before an in-progress frame is abandoned (200 µs at 100 MHz).
- `clk` in 1 — system clock, single clock domain.
- `rst_n` in 1 — asynchronous, active-low reset.
- `keyb_clk` in 1 — raw PS/2 clock, asynchronous.
- `kdata` in 1 — raw PS/2 data, asynchronous.
- `keys` out 5*NUM_PLAYERS — held-key bitmap; player p occupies bits [5p+4:5p], bit order up, left, down, right, fire.
- `code_valid` out 1 — one-cycle pulse per completed scancode event.
- `code_data` out 8 — final (non-prefix) scancode byte.
- `code_ext` out 1 — E0 preceded the code.
- `code_break` out 1 — F0 preceded the code (release).
- `parity_err` out 1 — one-cycle pulse on parity failure.
- `frame_err` out 1 — one-cycle pulse on bad stop bit or timeout.
- `debugLEDs` out 8 — last received raw byte, including prefixes.

## Operation
- Input lines pass through `SYNC_STAGES` flops. A falling edge of synchronised `keyb_clk` gives a one-cycle `fall` strobe. All sampling happens on `fall`.
- Frame FSM states:
  - IDLE: on `fall` with data 0, go to DATA; with data 1, stay in IDLE (glitch ignored).
  - DATA: shift 8 bits LSB first, then go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: data 1 means the byte is good; data 0 means `frame_err` and discard. Either way, return to IDLE.
- Timeout: an idle counter runs outside IDLE and resets on each `fall`. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, `frame_err` pulses, and the partial byte and prefix flags are cleared.
- Prefix layer, per good byte:
  - E0 sets `ext`.
  - F0 sets `brk`.
  - Any other byte emits an event (`code_valid`, `code_data`, `code_ext`=`ext`, `code_break`=`brk`), then clears both flags.
  - E1 and unmapped codes still emit an event but do not touch `keys`.
- Keymap, held in the package:
  - P1: 1D, 1C, 1B, 23, 29 (W, A, S, D, Space).
  - P2: E0 75, E0 6B, E0 72, E0 74, 5A (arrows, Enter).
  - A code must match both the byte and the `ext` flag.
  - A make sets the mapped bit; a break clears it; repeated makes are idempotent.
  - P2 entries are ignored when `NUM_PLAYERS`=1.
- `debugLEDs` updates on every good byte.
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE, flags cleared, counter 0.
  - Synchroniser flops reset to 1, the bus idle level.

## Timing
- The `fall` strobe is asserted `SYNC_STAGES`+1 cycles after the raw edge.
- Latency from the stop-bit `fall` strobe:
  - good byte registered and `debugLEDs` updated at +1;
  - `code_valid` pulse and `keys` update at +2.
- Error pulses (`parity_err`, `frame_err`) are asserted 1 cycle after the offending `fall`, or 1 cycle after the counter hits `TIMEOUT_CYCLES`.
- There is no backpressure: events are single-cycle pulses. Consecutive PS/2 bytes are at least ~600 µs apart, so pulses never overlap.
- If a timeout and a `fall` land in the same cycle, the `fall` wins and the counter clears.
- If `rst_n` is asserted mid-frame, all state clears immediately. After release, the FSM waits for a new start bit; the rest of the interrupted frame is rejected through the timeout or stop-bit checks.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - odd parity is checked over the 8 data bits plus the parity bit;
  - on mismatch, `parity_err` pulses, the byte is discarded, and prefix flags are cleared.
- `PS2_PARITY_CHECK_EN` undefined:
  - the parity bit is sampled and ignored;
  - `parity_err` is tied to 0.

## Structure
- `ps2_pkg`:
  - FSM state enum;
  - prefix constants E0, F0 and E1;
  - key-index constants for up, left, down, right, fire;
  - keymap constant array of {ext, code} per player and key.
- Sub-module `ps2_frame_rx` contains the synchroniser, edge detect, frame FSM, timeout and parity check. It outputs byte, byte_valid, parity_err and frame_err.
- The top level holds the prefix layer, keymap lookup and `keys` registers.

## Test plan
- Frame 1D with correct parity and stop 1 -> `debugLEDs`=8'h1D; `code_valid` with `code_data`=1D, ext 0, break 0; `keys[0]`=1.
- Frames E0, 75 -> `debugLEDs`=8'h75; `code_ext`=1; `keys[5]`=1. Then E0, F0, 75 -> `code_break`=1, `keys[5]`=0, `keys[0]` unchanged.
- Frame 1D with wrong parity -> with `PS2_PARITY_CHECK_EN`, `parity_err` pulses, `keys` unchanged, no `code_valid`. Without it, the key is registered.
- Start bit plus 4 data bits, then the line goes idle -> `frame_err` pulses `TIMEOUT_CYCLES` after the last edge. A following clean 29 frame sets `keys[4]`.
- Frame 5A with stop bit 0 -> `frame_err` pulses, no event. Then `NUM_PLAYERS`=1 with E0 75 -> event emitted, `keys` stays 5'b0.
- Assert `rst_n` low after the 6th bit of a frame -> all outputs 0 at once. Bench sends a clean 1C after release -> `keys[1]`=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keypad receiver: frame states,
// prefix bytes, key indices and the per-player {ext, code} keymap.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   localparam logic [7:0] CODE_E0 = 8'hE0;
   localparam logic [7:0] CODE_F0 = 8'hF0;
   localparam logic [7:0] CODE_E1 = 8'hE1;

   localparam int KEY_UP      = 0;
   localparam int KEY_LEFT    = 1;
   localparam int KEY_DOWN    = 2;
   localparam int KEY_RIGHT   = 3;
   localparam int KEY_FIRE    = 4;
   localparam int NUM_KEYS    = 5;
   localparam int MAX_PLAYERS = 2;

   // Entry = {ext, code}; order within a player is up, left, down, right, fire.
   localparam logic [8:0] KEYMAP [MAX_PLAYERS][NUM_KEYS] = '{
      '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h029},
      '{9'h175, 9'h16B, 9'h172, 9'h174, 9'h05A}
   };

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser and 11-bit frame deframer with inactivity timeout.
// Optional odd-parity check enabled by defining PS2_PARITY_CHECK_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data 0 on fall)
// ST_DATA   | shifting 8 data bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | checking the stop bit, delivering the byte if good
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       keyb_clk,
   input  logic       kdata,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   clk_prev;
   logic                   fall, din, timeout;

   frame_state_t state, state_nx;
   logic [2:0]   bit_cnt, bit_cnt_nx;
   logic [7:0]   shift, shift_nx, byte_nx;
   logic         par_bad, par_bad_nx;
   logic         valid_nx, perr_nx, ferr_nx;
   logic [CW-1:0] idle_cnt;

   // Flops reset to 1 so the idle bus does not look like a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], keyb_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], kdata};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign din     = data_sync[SYNC_STAGES-1];
   assign timeout = (state != ST_IDLE) && !fall && (idle_cnt == CW'(TIMEOUT_CYCLES));

   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      shift_nx   = shift;
      par_bad_nx = par_bad;
      byte_nx    = rx_byte;
      valid_nx   = 1'b0;
      perr_nx    = 1'b0;
      ferr_nx    = 1'b0;
      if (timeout) begin
         state_nx   = ST_IDLE;
         bit_cnt_nx = 3'd0;
         shift_nx   = 8'd0;
         par_bad_nx = 1'b0;
         ferr_nx    = 1'b1;
      end else if (fall) begin
         case (state)
            ST_IDLE: begin
               if (!din) begin
                  state_nx   = ST_DATA;
                  bit_cnt_nx = 3'd0;
                  shift_nx   = 8'd0;
                  par_bad_nx = 1'b0;
               end
            end
            ST_DATA: begin
               shift_nx   = {din, shift[7:1]};
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nx = ST_PARITY;
            end
            ST_PARITY: begin
               state_nx = ST_STOP;
`ifdef PS2_PARITY_CHECK_EN
               if (~^{shift, din}) begin
                  par_bad_nx = 1'b1;
                  perr_nx    = 1'b1;
               end
`endif
            end
            ST_STOP: begin
               state_nx = ST_IDLE;
               if (!din) begin
                  ferr_nx = 1'b1;
               end else if (!par_bad) begin
                  valid_nx = 1'b1;
                  byte_nx  = shift;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= 3'd0;
         shift      <= 8'd0;
         par_bad    <= 1'b0;
         rx_byte    <= 8'd0;
         byte_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         idle_cnt   <= '0;
      end else begin
         state      <= state_nx;
         bit_cnt    <= bit_cnt_nx;
         shift      <= shift_nx;
         par_bad    <= par_bad_nx;
         rx_byte    <= byte_nx;
         byte_valid <= valid_nx;
         parity_err <= perr_nx;
         frame_err  <= ferr_nx;
         if (state == ST_IDLE || fall || timeout) idle_cnt <= '0;
         else                                     idle_cnt <= idle_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_keypad_rx.sv
// PS/2 keyboard front end: prefix tracking, scancode events and held-key bitmap.
// Parity checking in the deframer is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keypad_rx
   import ps2_pkg::*;
#(
   parameter int NUM_PLAYERS    = 2,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     keyb_clk,
   input  logic                     kdata,
   output logic [5*NUM_PLAYERS-1:0] keys,
   output logic                     code_valid,
   output logic [7:0]               code_data,
   output logic                     code_ext,
   output logic                     code_break,
   output logic                     parity_err,
   output logic                     frame_err,
   output logic [7:0]               debugLEDs
);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_perr, rx_ferr;
   logic       ext, brk;

   ps2_frame_rx #(
      .SYNC_STAGES    (SYNC_STAGES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .keyb_clk   (keyb_clk),
      .kdata      (kdata),
      .rx_byte    (rx_byte),
      .byte_valid (rx_valid),
      .parity_err (rx_perr),
      .frame_err  (rx_ferr)
   );

   // The deframer only loads its byte register on good bytes.
   assign debugLEDs  = rx_byte;
   assign parity_err = rx_perr;
   assign frame_err  = rx_ferr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext        <= 1'b0;
         brk        <= 1'b0;
         keys       <= '0;
         code_valid <= 1'b0;
         code_data  <= 8'd0;
         code_ext   <= 1'b0;
         code_break <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         if (rx_perr || rx_ferr) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (rx_valid) begin
            if (rx_byte == CODE_E0) begin
               ext <= 1'b1;
            end else if (rx_byte == CODE_F0) begin
               brk <= 1'b1;
            end else begin
               code_valid <= 1'b1;
               code_data  <= rx_byte;
               code_ext   <= ext;
               code_break <= brk;
               ext        <= 1'b0;
               brk        <= 1'b0;
               if (rx_byte != CODE_E1) begin
                  for (int p = 0; p < NUM_PLAYERS; p++) begin
                     for (int k = 0; k < NUM_KEYS; k++) begin
                        if (KEYMAP[p][k] == {ext, rx_byte}) keys[NUM_KEYS*p + k] <= ~brk;
                     end
                  end
               end
            end
         end
      end
   end

endmodule
